spi_pkg_tx: RTL and testbench
=============================

Name: spi_pkg_tx

Overview:
Downstream consumer of ring_fifo in the DAQ_SPI path. Waits for package_ready, drains exactly PKG_SIZE bytes from the FIFO read port, and sends them as one framed SPI-master transaction: 3-byte header, payload, 1-byte checksum. The WiFi module is the SPI slave. Single clock domain; the block sits in the FIFO read domain.

Parameters:
PKG_SIZE, 38912, payload bytes per packet; must be ≥1 and ≤65535
CLK_DIV, 2, sys_clk cycles per SCLK half-period; must be ≥1
GAP_CYCLES, 16, minimum sys_clk cycles spi_cs_n stays high between packets
TIMEOUT, 1024, max sys_clk cycles to wait on a non-empty FIFO mid-packet
SYNC_BYTE, 8'hA5, first header byte

Ports:
sys_clk  in  1  clock; also the FIFO read clock
sys_rst  in  1  synchronous reset, active-high
enable  in  1  permits starting a new packet
package_ready  in  1  FIFO holds ≥ one full packet
fifo_empty  in  1  FIFO empty flag
fifo_valid  in  1  fifo_dout valid; 1 cycle after fifo_rd_en
fifo_dout  in  8  FIFO read data
fifo_rd_en  out  1  single-cycle read strobe
spi_sclk  out  1  SPI clock, mode 0 (idle low)
spi_cs_n  out  1  chip select, active low
spi_mosi  out  1  serial data, MSB first
busy  out  1  high from packet start until GAP ends
pkt_cnt  out  16  packets completed; wraps at 65535→0
underflow_err  out  1  sticky; set on FIFO timeout; cleared only by reset

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge, at any time, including mid-packet): next edge gives spi_cs_n=1, spi_sclk=0, spi_mosi=0, fifo_rd_en=0, busy=0, pkt_cnt=0, underflow_err=0, seq=0, state IDLE. No partial frame resumes.
- States: IDLE → LOAD → SHIFT → (FETCH → WAITV → SHIFT)* → GAP → IDLE.
- IDLE: when enable&&package_ready, latch seq, clear checksum, busy=1, spi_cs_n=0, load SYNC_BYTE, go to SHIFT.
- SHIFT: 8 bits per byte. Each bit takes 2*CLK_DIV cycles: mosi updates at bit start with sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles. The first rising edge of sclk comes CLK_DIV cycles after cs_n falls. Byte order: SYNC_BYTE, seq[15:8], seq[7:0], PKG_SIZE payload bytes, checksum. Sclk stays low between bytes.
- FETCH (before each payload byte): if !fifo_empty, pulse fifo_rd_en for exactly 1 cycle and go to WAITV.
- WAITV: on fifo_valid, capture fifo_dout, add it to checksum (8-bit sum mod 256 of payload only), go to SHIFT.
- Timeout: a wait counter runs in FETCH while the FIFO is empty. If it reaches TIMEOUT, set underflow_err, drive cs_n high, go to GAP, and leave pkt_cnt and seq unchanged. A fifo_valid that never arrives is counted the same way.
- Exactly PKG_SIZE rd_en pulses per completed packet. rd_en never asserts while fifo_empty=1 or outside FETCH.
- After the checksum byte's last sclk falling edge, cs_n rises one cycle later, then pkt_cnt and seq increment. Enter GAP.
- GAP: hold cs_n=1 for GAP_CYCLES cycles, then busy=0 and go to IDLE. A new packet may start on the next cycle.
- enable deasserted mid-packet: the current packet completes. It only gates starts from IDLE.
- package_ready is ignored outside IDLE. If it stays high after a packet, back-to-back packets follow, separated by GAP.
- Payload byte counter is 16 bits wide. Its terminal compare is PKG_SIZE-1.

Test Plan:
1. PKG_SIZE=10, CLK_DIV=2. FIFO preloaded with 0x01..0x0A, package_ready=1, enable=1 → one frame of 112 sclk rising edges; decoded bytes A5 00 00 01..0A 37; 10 rd_en pulses; pkt_cnt=1; cs_n high ≥16 cycles afterward.
2. package_ready held high with 20 bytes preloaded → two frames, second header A5 00 01, pkt_cnt=2; gap between cs_n rise and next fall ≥ GAP_CYCLES.
3. FIFO goes empty after 4 payload bytes, TIMEOUT=32 → underflow_err=1 on cycle 32 of waiting; cs_n=1; pkt_cnt stays 0; exactly 4 rd_en pulses.
4. Same as test 3, but the FIFO refills at wait cycle 20 → no error; the frame completes with the correct checksum.
5. sys_rst pulsed during the 3rd payload byte → next edge cs_n=1, sclk=0, busy=0, pkt_cnt=0; a fresh frame restarts with seq 0000.
6. enable dropped mid-frame → the frame completes with pkt_cnt=1; no new frame starts while enable=0 even with package_ready=1.

Source files
------------

// File: rtl/spi_pkg_tx_if.sv
// Bundle of the FIFO read port, SPI pins and status for spi_pkg_tx.
// master = the packet transmitter, slave = FIFO/SPI-slave/status side.
interface spi_pkg_tx_if;
  logic        enable;
  logic        package_ready;
  logic        fifo_empty;
  logic        fifo_valid;
  logic [7:0]  fifo_dout;
  logic        fifo_rd_en;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        underflow_err;

  modport master (
    input  enable, package_ready, fifo_empty, fifo_valid, fifo_dout,
    output fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi, busy, pkt_cnt, underflow_err
  );
  modport slave (
    output enable, package_ready, fifo_empty, fifo_valid, fifo_dout,
    input  fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi, busy, pkt_cnt, underflow_err
  );
endinterface

// File: rtl/spi_pkg_tx.sv
// Packet transmitter: drains PKG_SIZE bytes from a FIFO and sends them as one
// SPI mode-0 frame: SYNC, seq[15:8], seq[7:0], payload, 8-bit payload sum.
// GAP_CYCLES and TIMEOUT are expected to be >= 1.
module spi_pkg_tx #(
  parameter int         PKG_SIZE   = 38912,
  parameter int         CLK_DIV    = 2,
  parameter int         GAP_CYCLES = 16,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  spi_pkg_tx_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_FETCH, S_WAITV, S_GAP} state_t;

  // Which byte was last handed to the shifter; LOAD uses it to pick the next one.
  localparam logic [2:0] SEG_SYNC = 3'd0, SEG_SEQH = 3'd1, SEG_SEQL = 3'd2,
                         SEG_PAY  = 3'd3, SEG_CSUM = 3'd4;

  localparam logic [15:0] LAST_IDX = 16'(PKG_SIZE - 1);
  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_seg;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bit;
  logic [31:0] r_div;
  logic [31:0] r_wait;
  logic [31:0] r_gap;
  logic [15:0] r_pay_cnt;
  logic [15:0] r_seq;
  logic [15:0] r_seq_lat;
  logic [7:0]  r_csum;
  logic        r_sclk, r_cs_n, r_mosi, r_rd_en, r_busy, r_err;
  logic [15:0] r_pkt_cnt;

  assign bus.spi_sclk      = r_sclk;
  assign bus.spi_cs_n      = r_cs_n;
  assign bus.spi_mosi      = r_mosi;
  assign bus.fifo_rd_en    = r_rd_en;
  assign bus.busy          = r_busy;
  assign bus.pkt_cnt       = r_pkt_cnt;
  assign bus.underflow_err = r_err;

  // Frame sequencer: byte selection, bit shifting, FIFO fetch and inter-packet gap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_seg     <= SEG_SYNC;
      r_shreg   <= '0;
      r_bit     <= '0;
      r_div     <= '0;
      r_wait    <= '0;
      r_gap     <= '0;
      r_pay_cnt <= '0;
      r_seq     <= '0;
      r_seq_lat <= '0;
      r_csum    <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_rd_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.enable && bus.package_ready) begin
            r_seq_lat <= r_seq;
            r_csum    <= '0;
            r_busy    <= 1'b1;
            r_cs_n    <= 1'b0;
            r_shreg   <= SYNC_BYTE;
            r_mosi    <= SYNC_BYTE[7];
            r_bit     <= '0;
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_seg     <= SEG_SYNC;
            r_state   <= S_SHIFT;
          end
        end
        // Between bytes: sclk is low, pick what goes out next.
        S_LOAD: begin
          r_bit  <= '0;
          r_div  <= '0;
          r_wait <= '0;
          unique case (r_seg)
            SEG_SYNC: begin
              r_shreg <= r_seq_lat[15:8];
              r_mosi  <= r_seq_lat[15];
              r_seg   <= SEG_SEQH;
              r_state <= S_SHIFT;
            end
            SEG_SEQH: begin
              r_shreg <= r_seq_lat[7:0];
              r_mosi  <= r_seq_lat[7];
              r_seg   <= SEG_SEQL;
              r_state <= S_SHIFT;
            end
            SEG_SEQL: begin
              r_pay_cnt <= '0;
              r_seg     <= SEG_PAY;
              r_state   <= S_FETCH;
            end
            SEG_PAY: begin
              if (r_pay_cnt == LAST_IDX) begin
                r_shreg <= r_csum;
                r_mosi  <= r_csum[7];
                r_seg   <= SEG_CSUM;
                r_state <= S_SHIFT;
              end else begin
                r_pay_cnt <= r_pay_cnt + 16'd1;
                r_state   <= S_FETCH;
              end
            end
            default: begin
              // Checksum is out: close the frame and count it.
              r_cs_n    <= 1'b1;
              r_pkt_cnt <= r_pkt_cnt + 16'd1;
              r_seq     <= r_seq + 16'd1;
              r_gap     <= '0;
              r_state   <= S_GAP;
            end
          endcase
        end
        // Each bit: CLK_DIV cycles low (mosi already set), then CLK_DIV high.
        S_SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == 3'd7) begin
                r_state <= S_LOAD;
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_shreg <= {r_shreg[6:0], 1'b0};
                r_mosi  <= r_shreg[6];
              end
            end
          end else begin
            r_div <= r_div + 32'd1;
          end
        end
        S_FETCH: begin
          if (!bus.fifo_empty) begin
            r_rd_en <= 1'b1;
            r_wait  <= '0;
            r_state <= S_WAITV;
          end else if (r_wait == TO_LAST) begin
            r_err   <= 1'b1;
            r_cs_n  <= 1'b1;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        // A read that never returns data is treated like an empty FIFO.
        S_WAITV: begin
          if (bus.fifo_valid) begin
            r_shreg <= bus.fifo_dout;
            r_mosi  <= bus.fifo_dout[7];
            r_csum  <= r_csum + bus.fifo_dout;
            r_bit   <= '0;
            r_div   <= '0;
            r_state <= S_SHIFT;
          end else if (r_wait == TO_LAST) begin
            r_err   <= 1'b1;
            r_cs_n  <= 1'b1;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_pkg_tx.sv
// Bench for spi_pkg_tx: FIFO model, SPI frame decoder and a byte-level
// reference of the expected frame (header, payload, sum mod 256).
module tb_spi_pkg_tx;
  localparam int PKG = 10, DIV = 2, GAP = 16, TO = 32;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  spi_pkg_tx_if bus ();
  spi_pkg_tx #(.PKG_SIZE(PKG), .CLK_DIV(DIV), .GAP_CYCLES(GAP), .TIMEOUT(TO), .SYNC_BYTE(8'hA5))
    dut (.sys_clk(clk), .sys_rst(rst), .bus(bus.slave));

  int total = 0, bad = 0;

  // FIFO contents written by the main sequence, consumed by the FIFO model.
  logic [7:0] src [0:511];
  int src_lim = 0, skip_to = 0;
  int rd_idx = 0, rd_cnt = 0, rd_bad = 0;
  logic rd_prev = 1'b0;

  // FIFO model: data valid one cycle after a read strobe.
  always @(negedge clk) begin
    if (rd_idx < skip_to) rd_idx = skip_to;
    bus.fifo_valid = 1'b0;
    if (bus.fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (rd_idx >= src_lim || rd_prev) rd_bad++;
      if (rd_idx < src_lim) begin
        bus.fifo_dout  = src[rd_idx];
        rd_idx++;
        bus.fifo_valid = 1'b1;
      end
    end
    rd_prev = (bus.fifo_rd_en === 1'b1);
    bus.fifo_empty = (rd_idx >= src_lim);
  end

  // SPI decoder: shifts mosi on each sclk rise while cs_n is low.
  logic [7:0] mon [0:1023];
  int mon_n = 0, cyc = 0, nbits = 0, edges = 0, last_edges = 0;
  int frames_seen = 0, rise_cyc = -1, last_gap = 0, last_fall = 0;
  logic [7:0] sh = '0;
  logic m_sclk = 1'b0, m_cs = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (m_cs === 1'b1 && bus.spi_cs_n === 1'b0) begin
      nbits = 0; edges = 0;
      if (rise_cyc >= 0) last_gap = cyc - rise_cyc;
    end
    if (bus.spi_cs_n === 1'b0 && m_sclk === 1'b0 && bus.spi_sclk === 1'b1) begin
      edges++;
      sh = {sh[6:0], bus.spi_mosi};
      nbits++;
      if (nbits == 8) begin mon[mon_n] = sh; mon_n++; nbits = 0; end
    end
    if (m_sclk === 1'b1 && bus.spi_sclk === 1'b0) last_fall = cyc;
    if (m_cs === 1'b0 && bus.spi_cs_n === 1'b1) begin
      frames_seen++; last_edges = edges; rise_cyc = cyc;
    end
    m_sclk = bus.spi_sclk;
    m_cs   = bus.spi_cs_n;
  end

  // Reference frames and per-test baselines.
  logic [7:0] exp_b [0:511];
  int exp_n = 0, fb = 0, mb = 0, rb = 0, sb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mark();
    fb = frames_seen; mb = mon_n; rb = rd_cnt; sb = src_lim; exp_n = 0;
  endtask

  task automatic push(input logic [7:0] b);
    src[src_lim] = b; src_lim++;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push(8'($urandom_range(0, 255)));
  endtask

  // Reference frame: sync, seq big-endian, payload, payload sum mod 256.
  task automatic add_exp(input int seq, input int start, input int n_pay);
    int sum;
    sum = 0;
    exp_b[exp_n] = 8'hA5;           exp_n++;
    exp_b[exp_n] = 8'((seq >> 8) % 256); exp_n++;
    exp_b[exp_n] = 8'(seq % 256);   exp_n++;
    for (int i = 0; i < n_pay; i++) begin
      exp_b[exp_n] = src[start + i]; exp_n++;
      sum = sum + int'(src[start + i]);
    end
    if (n_pay == PKG) begin exp_b[exp_n] = 8'(sum % 256); exp_n++; end
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_len"}, mon_n - mb, exp_n);
    for (int i = 0; i < exp_n && (mb + i) < mon_n; i++)
      chk($sformatf("%s_b%0d", tag, i), mon[mb + i], exp_b[i]);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n;
    n = 0;
    while (frames_seen < target && n < 4000) begin tick(); n++; end
    chk(tag, 32'(frames_seen >= target), 1);
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int n;
    n = 0;
    while (mon_n < target && n < 4000) begin tick(); n++; end
    chk(tag, 32'(mon_n >= target), 1);
  endtask

  task automatic start(input logic keep_ready);
    int n;
    bus.enable = 1'b1; bus.package_ready = 1'b1;
    n = 0;
    while (bus.busy !== 1'b1 && n < 50) begin tick(); n++; end
    chk("start_busy", bus.busy, 1);
    if (!keep_ready) bus.package_ready = 1'b0;
  endtask

  // Reset, check the idle outputs, and discard anything left in the FIFO.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_cs_n", bus.spi_cs_n, 1);
    chk("rst_sclk", bus.spi_sclk, 0);
    chk("rst_mosi", bus.spi_mosi, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("rst_err", bus.underflow_err, 0);
    tick();
    skip_to = src_lim;
    rst = 1'b0;
  endtask

  initial begin
    int n, err_cyc;
    bus.enable = 1'b0; bus.package_ready = 1'b0;
    do_reset();

    // 1: one frame of 0x01..0x0A
    mark();
    for (int i = 1; i <= 10; i++) push(8'(i));
    start(1'b0);
    wait_frames(fb + 1, "t1_done");
    add_exp(0, sb, PKG);
    chk_frame("t1");
    chk("t1_csum", mon[mb + 13], 8'h37);
    chk("t1_edges", last_edges, 112);
    chk("t1_rd", rd_cnt - rb, 10);
    chk("t1_pkt", bus.pkt_cnt, 1);
    repeat (20) tick();
    chk("t1_cs_hi", bus.spi_cs_n, 1);
    chk("t1_busy", bus.busy, 0);
    chk("t1_nomore", frames_seen, fb + 1);

    // 2: back-to-back frames while package_ready stays high
    do_reset();
    mark();
    push_rand(20);
    start(1'b1);
    wait_frames(fb + 1, "t2_f1");
    n = 0;
    while (bus.spi_cs_n !== 1'b0 && n < 100) begin tick(); n++; end
    chk("t2_restart", bus.spi_cs_n, 0);
    bus.package_ready = 1'b0;
    wait_frames(fb + 2, "t2_f2");
    add_exp(0, sb, PKG);
    add_exp(1, sb + PKG, PKG);
    chk_frame("t2");
    chk("t2_pkt", bus.pkt_cnt, 2);
    chk("t2_gap", 32'(last_gap >= GAP), 1);
    chk("t2_rd", rd_cnt - rb, 20);
    repeat (60) tick();
    chk("t2_nomore", frames_seen, fb + 2);

    // 3: FIFO runs dry after 4 payload bytes
    do_reset();
    mark();
    push_rand(4);
    start(1'b0);
    n = 0;
    while (bus.underflow_err !== 1'b1 && n < 2000) begin tick(); n++; end
    err_cyc = cyc;
    chk("t3_err", bus.underflow_err, 1);
    chk("t3_err_time", 32'((err_cyc - last_fall) >= 30 && (err_cyc - last_fall) <= 36), 1);
    chk("t3_cs_n", bus.spi_cs_n, 1);
    chk("t3_pkt", bus.pkt_cnt, 0);
    chk("t3_rd", rd_cnt - rb, 4);
    add_exp(0, sb, 4);
    chk_frame("t3");
    repeat (40) tick();
    chk("t3_sticky", bus.underflow_err, 1);
    chk("t3_busy", bus.busy, 0);

    // 4: FIFO refills partway through the wait
    do_reset();
    mark();
    push_rand(4);
    start(1'b0);
    wait_bytes(mb + 7, "t4_part");
    repeat (22) tick();
    chk("t4_err_pre", bus.underflow_err, 0);
    push_rand(6);
    wait_frames(fb + 1, "t4_done");
    add_exp(0, sb, PKG);
    chk_frame("t4");
    chk("t4_err", bus.underflow_err, 0);
    chk("t4_pkt", bus.pkt_cnt, 1);
    chk("t4_rd", rd_cnt - rb, 10);

    // 5: reset during the 3rd payload byte, then a fresh frame
    do_reset();
    mark();
    push_rand(10);
    start(1'b1);
    wait_bytes(mb + 5, "t5_part");
    repeat (6) tick();
    do_reset();
    mark();
    push_rand(10);
    n = 0;
    while (bus.busy !== 1'b1 && n < 50) begin tick(); n++; end
    chk("t5_restart", bus.busy, 1);
    bus.package_ready = 1'b0;
    wait_frames(fb + 1, "t5_done");
    add_exp(0, sb, PKG);
    chk_frame("t5");
    chk("t5_pkt", bus.pkt_cnt, 1);

    // 6: enable dropped mid-frame
    do_reset();
    mark();
    push_rand(10);
    start(1'b1);
    wait_bytes(mb + 5, "t6_part");
    bus.enable = 1'b0;
    push_rand(10);
    wait_frames(fb + 1, "t6_done");
    add_exp(0, sb, PKG);
    chk_frame("t6");
    chk("t6_pkt", bus.pkt_cnt, 1);
    repeat (60) tick();
    chk("t6_nomore", frames_seen, fb + 1);
    chk("t6_cs_n", bus.spi_cs_n, 1);
    chk("t6_busy", bus.busy, 0);
    chk("t6_rd", rd_cnt - rb, 10);

    chk("rd_protocol", rd_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
